// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side serial drain.
package fifo_pkg;

  localparam int DATA_W = 3;

  // Serial frame line levels and total bit count (start + data + stop).
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam int   FRAME_BITS = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

endpackage

// File: rtl/fifo_serial_reader_bit_timer.sv
// Bit-period divider: tick marks the last cycle of every BIT_DIV-cycle bit.
module bit_timer #(
  parameter int BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] LAST_CNT = 8'(BIT_DIV - 1);

  logic [7:0] cnt_r;

  assign tick = run && (cnt_r == LAST_CNT);

  // Divide counter: held at 0 while cleared, returns to 0 after its terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= 8'd0;
    end else if (run) begin
      if (tick) begin
        cnt_r <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/fifo_serial_reader.sv
// Pops 3-bit words from the FIFO read port and sends each as a start/3-data/stop
// serial frame, LSB first. Outputs are registered from the next-state decode so
// they line up with the state they describe.
module fifo_serial_reader
  import fifo_pkg::*;
#(
  parameter int BIT_DIV = 4
) (
  input  logic              rclk,
  input  logic              rst,
  input  logic              en,
  input  logic              empy,
  input  logic [DATA_W-1:0] datout,
  output logic              rd,
  output logic              txd,
  output logic              busy
);

  // Index of the last data bit within the frame.
  localparam logic [1:0] LAST_BIT = 2'(FRAME_BITS - 3);

  state_t            state_r;
  state_t            state_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_s;
  logic [1:0]        bit_r;
  logic [1:0]        bit_s;
  logic              rd_r;
  logic              txd_r;
  logic              busy_r;
  logic              txd_s;
  logic              run_s;
  logic              tick_s;
  logic              can_pop_s;

  assign can_pop_s = en && !empy;
  assign run_s     = (state_r == START) || (state_r == DATA) || (state_r == STOP);

  bit_timer #(
    .BIT_DIV(BIT_DIV)
  ) u_bit_timer (
    .clk  (rclk),
    .rst  (rst),
    .clear(!run_s),
    .run  (run_s),
    .tick (tick_s)
  );

  // Next-state, shift register and bit counter decode.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    bit_s   = bit_r;
    case (state_r)
      IDLE: begin
        if (can_pop_s) begin
          state_s = POP;
        end else begin
          state_s = IDLE;
        end
      end
      POP: begin
        state_s = LOAD;
      end
      LOAD: begin
        shift_s = datout;
        bit_s   = 2'd0;
        state_s = START;
      end
      START: begin
        if (tick_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (bit_r == LAST_BIT) begin
            state_s = STOP;
          end else begin
            bit_s   = bit_r + 2'd1;
            shift_s = {1'b0, shift_r[DATA_W-1:1]};
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (can_pop_s) begin
            state_s = POP;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, taken from the next state and shift value.
  always_comb begin
    txd_s = STOP_LVL;
    case (state_s)
      START:   txd_s = START_LVL;
      DATA:    txd_s = shift_s[0];
      default: txd_s = STOP_LVL;
    endcase
  end

  // State, datapath and registered outputs; reset drops any in-flight word.
  always_ff @(posedge rclk) begin
    if (rst) begin
      state_r <= IDLE;
      shift_r <= '0;
      bit_r   <= 2'd0;
      rd_r    <= 1'b0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      bit_r   <= bit_s;
      rd_r    <= (state_s == POP);
      txd_r   <= txd_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign rd   = rd_r;
  assign txd  = txd_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Bench for fifo_serial_reader: lane 0 uses BIT_DIV=4, lane 1 uses BIT_DIV=1.
// Each lane has a small FIFO model; expected words go into a per-lane queue and
// a monitor decodes txd frames and compares them against that queue.
module tb_fifo_serial_reader;

  logic       clk;
  logic       rst;
  logic [1:0] en;
  logic [1:0] empy;
  logic [1:0] rd;
  logic [1:0] txd;
  logic [1:0] busy;
  logic [2:0] datout [2];

  logic [2:0] mem [2][16];
  int         wp [2] = '{0, 0};
  int         rp [2] = '{0, 0};
  logic [2:0] exp_q [2][$];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    fifo_serial_reader #(
      .BIT_DIV(g == 0 ? 4 : 1)
    ) u_dut (
      .rclk  (clk),
      .rst   (rst),
      .en    (en[g]),
      .empy  (empy[g]),
      .datout(datout[g]),
      .rd    (rd[g]),
      .txd   (txd[g]),
      .busy  (busy[g])
    );
    assign empy[g] = (rp[g] == wp[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model read port: data registered the cycle after rd.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rd[g]) begin
        datout[g] <= mem[g][rp[g] % 16];
        rp[g]     <= rp[g] + 1;
      end
    end
  end

  // Monitor state.
  int         bd [2] = '{4, 1};
  logic       in_frame [2];
  int         cyc [2];
  logic [4:0] pat [2];
  logic [4:0] obs [2];
  logic       bad [2];
  int         idle_cnt [2];
  logic       chk_gap [2];
  logic       chk_busy [2];
  logic       exp_busy [2];
  int         rd_age [2];
  logic       rd_prev [2];
  int         rd_cnt [2] = '{0, 0};
  int         frames [2] = '{0, 0};
  logic [2:0] cur_w [2];

  // Frame decoder and scoreboard compare, sampled on the falling edge.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        in_frame[g] = 1'b0;
        chk_gap[g]  = 1'b0;
        chk_busy[g] = 1'b0;
        idle_cnt[g] = 0;
        rd_age[g]   = 100;
        rd_prev[g]  = 1'b0;
      end else begin
        if (rd[g]) begin
          checks++;
          rd_cnt[g]++;
          if (empy[g] || rd_prev[g]) begin
            errors++;
            $display("FAIL rd_pulse[%0d]: empy=%0b prev_rd=%0b, required empy=0 prev_rd=0", g, empy[g], rd_prev[g]);
          end
          rd_age[g] = 0;
        end else if (rd_age[g] < 100) begin
          rd_age[g]++;
        end
        rd_prev[g] = rd[g];
        if (chk_busy[g]) begin
          checks++;
          if (busy[g] !== exp_busy[g]) begin
            errors++;
            $display("FAIL busy_after_stop[%0d]: got %0b, required %0b", g, busy[g], exp_busy[g]);
          end
          chk_busy[g] = 1'b0;
        end
        if (in_frame[g]) begin
          if (txd[g] !== pat[g][cyc[g] / bd[g]]) bad[g] = 1'b1;
          if (cyc[g] % bd[g] == 0) obs[g][cyc[g] / bd[g]] = txd[g];
          if (cyc[g] == 5 * bd[g] - 1) begin
            checks++;
            if (bad[g]) begin
              errors++;
              $display("FAIL frame[%0d]: word %0d got bits %b, required %b (stop..start)", g, cur_w[g], obs[g], pat[g]);
            end
            in_frame[g] = 1'b0;
            idle_cnt[g] = 0;
            exp_busy[g] = en[g] && !empy[g];
            chk_gap[g]  = exp_busy[g];
            chk_busy[g] = 1'b1;
          end else begin
            cyc[g]++;
          end
        end else if (txd[g] == 1'b0) begin
          frames[g]++;
          checks++;
          if (exp_q[g].size() == 0) begin
            errors++;
            cur_w[g] = 3'd0;
            $display("FAIL unexpected_frame[%0d]: got a start bit, required none", g);
          end else begin
            cur_w[g] = exp_q[g].pop_front();
          end
          pat[g] = {1'b1, cur_w[g], 1'b0};
          obs[g] = 5'd0;
          checks++;
          if (rd_age[g] != 2) begin
            errors++;
            $display("FAIL rd_to_start[%0d]: got %0d cycles, required 2", g, rd_age[g]);
          end
          if (chk_gap[g]) begin
            checks++;
            if (idle_cnt[g] != 2) begin
              errors++;
              $display("FAIL frame_gap[%0d]: got %0d idle cycles, required 2", g, idle_cnt[g]);
            end
          end
          bad[g]      = 1'b0;
          cyc[g]      = 1;
          in_frame[g] = 1'b1;
        end else begin
          idle_cnt[g]++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int g, input logic [2:0] w, input logic tx);
    mem[g][wp[g] % 16] = w;
    wp[g] = wp[g] + 1;
    if (tx) exp_q[g].push_back(w);
  endtask

  task automatic wait_done(input int g, input int budget, input string name);
    int n = 0;
    while ((exp_q[g].size() != 0 || busy[g]) && n < budget) begin
      tick(1);
      n++;
    end
    check(name, (n < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_frames(input int g, input int target, input string name);
    int n = 0;
    while (frames[g] < target && n < 300) begin
      tick(1);
      n++;
    end
    check(name, (frames[g] >= target) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    int r0;
    int f0;
    rst = 1'b1;
    en  = 2'b01;

    // Reset held 3 cycles with a non-empty FIFO: outputs stay at reset values.
    push(0, 3'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_rd", rd[0], 0);
      check("reset_txd", txd[0], 1);
      check("reset_busy", busy[0], 0);
    end
    rst = 1'b0;
    tick(1);
    check("first_rd_after_reset", rd[0], 1);
    n = 0;
    while (busy[0] && n < 100) begin
      n++;
      tick(1);
    end
    check("busy_cycles_from_rd", n, 22);
    wait_done(0, 100, "single_word_done");
    check("single_word_rd_count", rd_cnt[0], 1);

    // Six back-to-back words.
    r0 = rd_cnt[0];
    push(0, 3'd2, 1'b1);
    push(0, 3'd6, 1'b1);
    push(0, 3'd4, 1'b1);
    push(0, 3'd1, 1'b1);
    push(0, 3'd7, 1'b1);
    push(0, 3'd4, 1'b1);
    wait_done(0, 400, "six_words_done");
    check("six_words_rd_count", rd_cnt[0] - r0, 6);
    check("six_words_fifo_empty", empy[0], 1);

    // en dropped during DATA of word 2: word 2 finishes, third word stays queued.
    r0 = rd_cnt[0];
    f0 = frames[0];
    push(0, 3'd3, 1'b1);
    push(0, 3'd5, 1'b1);
    push(0, 3'd2, 1'b0);
    wait_frames(0, f0 + 2, "en_drop_reach_word2");
    tick(6);
    en[0] = 1'b0;
    wait_done(0, 200, "en_drop_done");
    check("en_drop_busy_idle", busy[0], 0);
    check("en_drop_fifo_nonempty", empy[0], 0);
    check("en_drop_rd_count", rd_cnt[0] - r0, 2);
    tick(20);
    check("en_drop_no_more_rd", rd_cnt[0] - r0, 2);
    en[0] = 1'b1;
    exp_q[0].push_back(3'd2);
    wait_done(0, 100, "en_restore_drain");

    // Reset in the middle of the second data bit; aborted word is not resent.
    r0 = rd_cnt[0];
    f0 = frames[0];
    push(0, 3'd5, 1'b1);
    push(0, 3'd3, 1'b1);
    push(0, 3'd6, 1'b1);
    wait_frames(0, f0 + 1, "abort_reach_frame");
    tick(9);
    rst = 1'b1;
    tick(1);
    check("abort_txd", txd[0], 1);
    check("abort_busy", busy[0], 0);
    check("abort_rd", rd[0], 0);
    rst = 1'b0;
    wait_done(0, 200, "abort_resume_done");
    check("abort_rd_count", rd_cnt[0] - r0, 3);

    // BIT_DIV=1 lane: 5-cycle frames, 2-cycle gaps.
    en[1] = 1'b1;
    push(1, 3'd1, 1'b1);
    push(1, 3'd2, 1'b1);
    push(1, 3'd7, 1'b1);
    push(1, 3'd0, 1'b1);
    wait_done(1, 200, "div1_done");
    check("div1_rd_count", rd_cnt[1], 4);
    tick(10);
    check("div1_idle_rd_count", rd_cnt[1], 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
